// File: rtl/sa_tile_sequencer_if.sv
// ---------------------------------------------------------------------------
// sa_tile_sequencer_if
// Bundles the control/handshake signals between the host/start logic, the
// SA_Data_Loader blocks (weight preloader, input feeder) and the tile
// sequencer.
//
// Signals (directions seen from the sequencer):
//   start_i         in   begin a job (sampled only while idle)
//   abort_i         in   synchronous abort
//   num_tiles_i     in   tile count, latched on an accepted start
//   preload_done_i  in   one-cycle pulse: all 9 weights loaded
//   feed_done_i     in   one-cycle pulse: last activation issued
//   preload_en_o    out  enable to the weight preloader
//   feed_en_o       out  enable to the input feeder
//   capture_o       out  one-cycle pulse: latch the array outputs
//   tile_idx_o      out  index of the current tile, from 0
//   busy_o          out  high whenever the sequencer is not idle
//   done_o          out  one-cycle pulse on normal job completion
//   state_o         out  current state code, for debug
//
// Modports: master = host / loader side, slave = the sequencer itself.
// ---------------------------------------------------------------------------
interface sa_tile_sequencer_if #(
    parameter int TILE_W = 8
);
    logic              start_i;
    logic              abort_i;
    logic [TILE_W-1:0] num_tiles_i;
    logic              preload_done_i;
    logic              feed_done_i;
    logic              preload_en_o;
    logic              feed_en_o;
    logic              capture_o;
    logic [TILE_W-1:0] tile_idx_o;
    logic              busy_o;
    logic              done_o;
    logic [2:0]        state_o;

    modport master (
        output start_i, abort_i, num_tiles_i, preload_done_i, feed_done_i,
        input  preload_en_o, feed_en_o, capture_o, tile_idx_o, busy_o,
               done_o, state_o
    );

    modport slave (
        input  start_i, abort_i, num_tiles_i, preload_done_i, feed_done_i,
        output preload_en_o, feed_en_o, capture_o, tile_idx_o, busy_o,
               done_o, state_o
    );
endinterface

// File: rtl/sa_tile_sequencer.sv
// ---------------------------------------------------------------------------
// sa_tile_sequencer
// Top-level sequencer for the 3x3 systolic array data path. Each tile runs
// weight preload, input feed, a fixed drain window and output capture; the
// sequence repeats for the number of tiles latched at start.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   sa_tile_sequencer_if.slave (start/abort/count in, loader done
//         pulses in, enables/capture/done/tile index/busy/state out)
//
// Parameters:
//   TILE_W        width of tile count and tile index
//   DRAIN_CYCLES  cycles spent in DRAIN after feed_done_i (1..255)
//   CNT_W         width of the drain counter
// ---------------------------------------------------------------------------
module sa_tile_sequencer #(
    parameter int TILE_W       = 8,
    parameter int DRAIN_CYCLES = 7,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sa_tile_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRELOAD = 3'd1,
        S_FEED    = 3'd2,
        S_DRAIN   = 3'd3,
        S_NEXT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [TILE_W-1:0] tile_idx;
    logic [TILE_W-1:0] tile_count;
    logic [CNT_W-1:0]  drain_cnt;
    logic              capture_q;
    logic              done_q;

    logic              start_job;
    logic              load_drain;
    logic              dec_drain;
    logic              fire_capture;
    logic              advance_tile;
    logic [TILE_W:0]   tile_next;
    logic              last_tile;

    // The compare is done one bit wider so that the +1 can never wrap and
    // alias a small tile count.
    assign tile_next = {1'b0, tile_idx} + {{TILE_W{1'b0}}, 1'b1};
    assign last_tile = (tile_next == {1'b0, tile_count});

    // Next-state and per-cycle control decode. Abort overrides every other
    // transition, including done pulses arriving in the same cycle, and in
    // IDLE it also suppresses a simultaneous start. Codes 6 and 7 fall back
    // to IDLE through the default branch.
    always_comb begin
        next_state   = state;
        start_job    = 1'b0;
        load_drain   = 1'b0;
        dec_drain    = 1'b0;
        fire_capture = 1'b0;
        advance_tile = 1'b0;
        if (bus.abort_i) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (bus.num_tiles_i != '0) begin
                            start_job  = 1'b1;
                            next_state = S_PRELOAD;
                        end else begin
                            next_state = S_DONE;
                        end
                    end
                end
                S_PRELOAD: begin
                    if (bus.preload_done_i) next_state = S_FEED;
                end
                S_FEED: begin
                    if (bus.feed_done_i) begin
                        load_drain = 1'b1;
                        next_state = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        fire_capture = 1'b1;
                        next_state   = S_NEXT;
                    end else begin
                        dec_drain = 1'b1;
                    end
                end
                S_NEXT: begin
                    if (last_tile) begin
                        next_state = S_DONE;
                    end else begin
                        advance_tile = 1'b1;
                        next_state   = S_PRELOAD;
                    end
                end
                S_DONE: begin
                    next_state = S_IDLE;
                end
                default: begin
                    next_state = S_IDLE;
                end
            endcase
        end
    end

    // State register plus the job datapath. capture and done are registered
    // from the decode so each shows up for exactly one cycle: capture while
    // in NEXT, done while in DONE. Reset discards any pending pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tile_idx   <= '0;
            tile_count <= '0;
            drain_cnt  <= '0;
            capture_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state     <= next_state;
            capture_q <= fire_capture;
            done_q    <= (next_state == S_DONE);
            if (start_job) begin
                tile_count <= bus.num_tiles_i;
                tile_idx   <= '0;
            end else if (advance_tile) begin
                tile_idx <= tile_idx + {{(TILE_W-1){1'b0}}, 1'b1};
            end
            if (load_drain) begin
                drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
            end else if (dec_drain) begin
                drain_cnt <= drain_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.preload_en_o = (state == S_PRELOAD);
    assign bus.feed_en_o    = (state == S_FEED);
    assign bus.busy_o       = (state != S_IDLE);
    assign bus.state_o      = state;
    assign bus.capture_o    = capture_q;
    assign bus.done_o       = done_q;
    assign bus.tile_idx_o   = tile_idx;

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sa_tile_sequencer
// Directed bench for sa_tile_sequencer. The stimulus process pushes the
// capture/done events it expects into a queue; a monitor pops one entry for
// every capture_o or done_o pulse the DUT presents and checks it. Enable and
// drain residency is counted by the monitor and checked per scenario.
// ---------------------------------------------------------------------------
module tb_sa_tile_sequencer;

    localparam int TILE_W = 8;

    typedef struct {
        bit         is_done;
        logic [7:0] tile;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    int n_pre   = 0;
    int n_feed  = 0;
    int n_drain = 0;
    int n_cap   = 0;
    int n_done  = 0;

    int s_pre, s_feed, s_drain, s_cap, s_done;

    exp_t exp_q[$];

    sa_tile_sequencer_if #(.TILE_W(TILE_W)) bus ();

    sa_tile_sequencer #(
        .TILE_W      (TILE_W),
        .DRAIN_CYCLES(7),
        .CNT_W       (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: counts enable/drain residency and scores every output pulse
    // against the next queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.preload_en_o) n_pre++;
        if (bus.feed_en_o) n_feed++;
        if (bus.state_o == 3'd3) n_drain++;
        if (bus.capture_o) begin
            n_cap++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_capture", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("capture_kind", 0, {31'd0, e.is_done});
                checkOutput("capture_tile", {24'd0, bus.tile_idx_o}, {24'd0, e.tile});
                checkOutput("capture_state", {29'd0, bus.state_o}, 4);
            end
        end
        if (bus.done_o) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("done_kind", 1, {31'd0, e.is_done});
                checkOutput("done_tile", {24'd0, bus.tile_idx_o}, {24'd0, e.tile});
                checkOutput("done_state", {29'd0, bus.state_o}, 5);
            end
        end
    end

    task automatic pushExp(input bit is_done, input int tile);
        exp_t e;
        e.is_done = is_done;
        e.tile    = tile[7:0];
        exp_q.push_back(e);
    endtask

    task automatic snap();
        s_pre   = n_pre;
        s_feed  = n_feed;
        s_drain = n_drain;
        s_cap   = n_cap;
        s_done  = n_done;
    endtask

    task automatic waitState(input logic [2:0] code, input int budget);
        int n = 0;
        while (bus.state_o !== code && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.state_o !== code) checkOutput("wait_state_timeout", {29'd0, bus.state_o}, {29'd0, code});
    endtask

    task automatic waitIdle();
        waitState(3'd0, 200);
        repeat (4) @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge one cycle later.
    task automatic applyStimulus(input int num_tiles);
        bus.start_i     = 1'b1;
        bus.num_tiles_i = num_tiles[7:0];
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // One tile: preload_done in PRELOAD cycle 10, feed_done in FEED cycle 6.
    // Returns on the falling edge of DRAIN cycle 1.
    task automatic driveTile();
        waitState(3'd1, 100);
        repeat (9) @(negedge clk);
        bus.preload_done_i = 1'b1;
        @(negedge clk);
        bus.preload_done_i = 1'b0;
        waitState(3'd2, 10);
        repeat (5) @(negedge clk);
        bus.feed_done_i = 1'b1;
        @(negedge clk);
        bus.feed_done_i = 1'b0;
    endtask

    task automatic checkDeltas(input string tag, input int pre, input int feed,
                               input int drain, input int cap, input int done);
        checkOutput({tag, "_preload_cycles"}, n_pre - s_pre, pre);
        checkOutput({tag, "_feed_cycles"}, n_feed - s_feed, feed);
        checkOutput({tag, "_drain_cycles"}, n_drain - s_drain, drain);
        checkOutput({tag, "_captures"}, n_cap - s_cap, cap);
        checkOutput({tag, "_dones"}, n_done - s_done, done);
        checkOutput({tag, "_queue_left"}, exp_q.size(), 0);
        checkOutput({tag, "_busy_after"}, {31'd0, bus.busy_o}, 0);
    endtask

    initial begin
        bus.start_i        = 1'b0;
        bus.abort_i        = 1'b0;
        bus.num_tiles_i    = '0;
        bus.preload_done_i = 1'b0;
        bus.feed_done_i    = 1'b0;
        doReset();

        // Reset state
        checkOutput("rst_state", {29'd0, bus.state_o}, 0);
        checkOutput("rst_busy", {31'd0, bus.busy_o}, 0);
        checkOutput("rst_preload_en", {31'd0, bus.preload_en_o}, 0);
        checkOutput("rst_feed_en", {31'd0, bus.feed_en_o}, 0);
        checkOutput("rst_capture", {31'd0, bus.capture_o}, 0);
        checkOutput("rst_done", {31'd0, bus.done_o}, 0);
        checkOutput("rst_tile_idx", {24'd0, bus.tile_idx_o}, 0);

        // 1: single tile
        $display("[TB] scenario 1: single tile");
        snap();
        pushExp(0, 0);
        pushExp(1, 0);
        applyStimulus(1);
        checkOutput("t1_state_preload", {29'd0, bus.state_o}, 1);
        checkOutput("t1_busy", {31'd0, bus.busy_o}, 1);
        driveTile();
        checkOutput("t1_state_drain", {29'd0, bus.state_o}, 3);
        waitIdle();
        checkDeltas("t1", 10, 6, 7, 1, 1);

        // 2: three tiles
        $display("[TB] scenario 2: three tiles");
        snap();
        pushExp(0, 0);
        pushExp(0, 1);
        pushExp(0, 2);
        pushExp(1, 2);
        applyStimulus(3);
        for (int t = 0; t < 3; t++) driveTile();
        waitIdle();
        checkDeltas("t2", 30, 18, 21, 3, 1);
        checkOutput("t2_tile_idx_final", {24'd0, bus.tile_idx_o}, 2);

        // 3: zero tiles
        $display("[TB] scenario 3: zero tiles");
        doReset();
        snap();
        pushExp(1, 0);
        applyStimulus(0);
        checkOutput("t3_state_done", {29'd0, bus.state_o}, 5);
        @(negedge clk);
        checkOutput("t3_state_idle", {29'd0, bus.state_o}, 0);
        waitIdle();
        checkDeltas("t3", 0, 0, 0, 0, 1);

        // 4a: abort during DRAIN of tile 1 of 3
        $display("[TB] scenario 4: abort");
        snap();
        pushExp(0, 0);
        applyStimulus(3);
        driveTile();
        driveTile();
        repeat (2) @(negedge clk);
        checkOutput("t4_pre_abort_state", {29'd0, bus.state_o}, 3);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        checkOutput("t4_abort_state", {29'd0, bus.state_o}, 0);
        checkOutput("t4_abort_tile_idx", {24'd0, bus.tile_idx_o}, 1);
        repeat (12) @(negedge clk);
        checkDeltas("t4a", 20, 12, 10, 1, 0);
        checkOutput("t4_tile_idx_held", {24'd0, bus.tile_idx_o}, 1);

        // 4b: feed_done and abort coincident in FEED
        snap();
        applyStimulus(1);
        repeat (9) @(negedge clk);
        bus.preload_done_i = 1'b1;
        @(negedge clk);
        bus.preload_done_i = 1'b0;
        repeat (2) @(negedge clk);
        bus.feed_done_i = 1'b1;
        bus.abort_i     = 1'b1;
        @(negedge clk);
        bus.feed_done_i = 1'b0;
        bus.abort_i     = 1'b0;
        checkOutput("t4b_abort_state", {29'd0, bus.state_o}, 0);
        repeat (12) @(negedge clk);
        checkDeltas("t4b", 10, 3, 0, 0, 0);

        // 5: spurious pulses
        $display("[TB] scenario 5: spurious pulses");
        snap();
        pushExp(0, 0);
        pushExp(1, 0);
        applyStimulus(1);
        bus.feed_done_i = 1'b1;
        @(negedge clk);
        bus.feed_done_i = 1'b0;
        checkOutput("t5_feed_done_in_preload", {29'd0, bus.state_o}, 1);
        repeat (8) @(negedge clk);
        bus.preload_done_i = 1'b1;
        @(negedge clk);
        bus.preload_done_i = 1'b0;
        @(negedge clk);
        bus.preload_done_i = 1'b1;
        @(negedge clk);
        bus.preload_done_i = 1'b0;
        checkOutput("t5_preload_done_in_feed", {29'd0, bus.state_o}, 2);
        repeat (3) @(negedge clk);
        bus.feed_done_i = 1'b1;
        @(negedge clk);
        bus.feed_done_i = 1'b0;
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.num_tiles_i = 8'd5;
        @(negedge clk);
        bus.start_i = 1'b0;
        checkOutput("t5_start_in_drain", {29'd0, bus.state_o}, 3);
        waitIdle();
        checkDeltas("t5", 10, 6, 7, 1, 1);

        // 6: async reset mid-FEED, then a normal two-tile job
        $display("[TB] scenario 6: async reset");
        applyStimulus(3);
        repeat (9) @(negedge clk);
        bus.preload_done_i = 1'b1;
        @(negedge clk);
        bus.preload_done_i = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t6_rst_state", {29'd0, bus.state_o}, 0);
        checkOutput("t6_rst_feed_en", {31'd0, bus.feed_en_o}, 0);
        checkOutput("t6_rst_busy", {31'd0, bus.busy_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        snap();
        pushExp(0, 0);
        pushExp(0, 1);
        pushExp(1, 1);
        applyStimulus(2);
        driveTile();
        driveTile();
        waitIdle();
        checkDeltas("t6", 20, 12, 14, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sa_tile_sequencer.md
Name: sa_tile_sequencer

Overview:
Top-level sequencer for the 3x3 systolic array data path. For each tile it runs weight preload, then input feed, then a fixed drain window, then output capture, and repeats for a programmed number of tiles. It drives the preloader enable and the input-feeder enable, and consumes their done pulses. It sits between the host/start logic and the SA_Data_Loader blocks.

Parameters:
TILE_W, 8, width of tile count and tile index
DRAIN_CYCLES, 7, cycles to wait after feed_done_i before results are valid; legal range 1..255
CNT_W, 8, width of drain counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
start_i  in  1  begin a job; sampled only in IDLE
abort_i  in  1  synchronous abort; valid in any state
num_tiles_i  in  TILE_W  tile count; latched on accepted start
preload_done_i  in  1  one-cycle pulse from the weight preloader when all 9 weights are loaded
feed_done_i  in  1  one-cycle pulse from the input feeder when the last activation has been issued
preload_en_o  out  1  enable to the weight preloader
feed_en_o  out  1  enable to the input feeder
capture_o  out  1  one-cycle pulse: array outputs are valid and must be latched
tile_idx_o  out  TILE_W  index of the current tile, from 0
busy_o  out  1  high in any state other than IDLE
done_o  out  1  one-cycle pulse when the job completes normally
state_o  out  3  current state encoding, for debug

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. All flops use clk and rst.
- Reset values:
  - state = IDLE
  - all output pulses and enables = 0
  - tile_idx_o = 0
  - latched tile count = 0
  - drain counter = 0
- Output timing: state is registered. preload_en_o, feed_en_o, busy_o and state_o are Moore-decoded from state. capture_o and done_o are registered pulses, each exactly one cycle.
- State encoding: IDLE=0, PRELOAD=1, FEED=2, DRAIN=3, NEXT=4, DONE=5. Codes 6 and 7 go to IDLE on the next edge.
- IDLE:
  - start_i=1 and num_tiles_i≠0: latch num_tiles_i, clear tile_idx_o, go to PRELOAD.
  - start_i=1 and num_tiles_i=0: go to DONE (done pulse, no enables asserted).
- PRELOAD: preload_en_o=1. When preload_done_i=1, go to FEED on the next edge. preload_en_o is therefore high in the cycle the done pulse is sampled, then low.
- FEED: feed_en_o=1. When feed_done_i=1, load the drain counter with DRAIN_CYCLES-1 and go to DRAIN.
- DRAIN: decrement the counter each cycle. When counter=0, pulse capture_o (visible the cycle after) and go to NEXT. Total DRAIN residency is exactly DRAIN_CYCLES cycles.
- NEXT: one cycle.
  - tile_idx_o+1 == latched count: go to DONE; tile_idx_o holds.
  - Otherwise: tile_idx_o increments and state goes to PRELOAD.
- DONE: one cycle, then IDLE. done_o is high during the cycle the state is DONE.
- Done pulses arriving outside their state (preload_done_i outside PRELOAD, feed_done_i outside FEED) are ignored.
- abort_i=1:
  - In any non-IDLE state: next state is IDLE, enables drop next cycle, no capture_o, no done_o, tile_idx_o holds its value.
  - Abort takes priority over all transitions, including simultaneous done pulses.
  - abort_i and start_i together in IDLE: stay in IDLE.
- start_i while busy: ignored. num_tiles_i changes while busy: ignored.
- Async reset mid-operation: immediate return to reset values. A pending capture_o or done_o is discarded.
- tile_idx_o wraps never. Maximum tiles = 2^TILE_W-1.

Test Plan:
1. Single tile: reset, start with num_tiles=1; preload_done 9 cycles after entering PRELOAD; feed_done 5 cycles into FEED -> preload_en high 10 cycles, feed_en high 6 cycles, DRAIN 7 cycles, one capture_o, done_o one cycle, then IDLE; busy low after.
2. Three tiles, same stimulus per tile -> three capture_o pulses; tile_idx sequence 0,1,2; done_o once, after the third capture; tile_idx=2 at done.
3. num_tiles=0 with start -> IDLE→DONE→IDLE; done_o 1 cycle; preload_en, feed_en and capture_o never asserted.
4. Abort during DRAIN of tile 1 (of 3), with feed_done and abort coincident in FEED of another run -> IDLE next cycle; no capture_o, no done_o; tile_idx holds 1.
5. Spurious pulses: preload_done_i in FEED, feed_done_i in PRELOAD, start_i in DRAIN -> no state change and no double capture.
6. Async rst asserted mid-FEED between clock edges -> outputs zero immediately; after release, start with num_tiles=2 completes normally with 2 captures.
